mem_wb_pipe: RTL and testbench

- Parametrised MEM/WB pipeline stage with a valid/ready handshake, an optional 2-entry skid buffer, and synchronous flush.
- The write-back value is formed inside the stage: the result select and the load-width extension happen here, so the WB side receives one ready-to-write data word.
- Sits between the data-memory stage and the register file. Also drives the WB forwarding source.

---
 rtl/mem_wb_pipe.sv | 170 +++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: forms the write-back word (result select + load
// extension) and registers it behind a valid/ready handshake, with an
// optional 2-entry skid buffer and synchronous flush.
module mem_wb_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 20,
   parameter int unsigned REG_W = 5,
   parameter int unsigned SKID  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pcplus4,
   input  logic [PC_W-1:0]  in_branch_addr,
   input  logic [XLEN-1:0]  in_immediate,
   input  logic             in_regwrite,
   input  logic [2:0]       in_sel,
   input  logic [2:0]       in_funct,
   input  logic [XLEN-1:0]  in_rdata,
   input  logic [XLEN-1:0]  in_alu,
   input  logic [REG_W-1:0] in_rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_wdata,
   output logic             out_regwrite,
   output logic [REG_W-1:0] out_rd
);

   localparam logic [2:0] SEL_ALU  = 3'b000;
   localparam logic [2:0] SEL_LOAD = 3'b001;
   localparam logic [2:0] SEL_IMM  = 3'b010;
   localparam logic [2:0] SEL_BR   = 3'b011;
   localparam logic [2:0] SEL_PC4  = 3'b100;

   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;

   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [XLEN-1:0]  ld_data;
   logic [XLEN-1:0]  wb_data_c;
   logic             wb_we_c;

   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_wdata_q, main_wdata_d;
   logic [REG_W-1:0] main_rd_q,    main_rd_d;
   logic             main_we_q,    main_we_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_wdata_q, skid_wdata_d;
   logic [REG_W-1:0] skid_rd_q,    skid_rd_d;
   logic             skid_we_q,    skid_we_d;
   logic             in_ready_q,   in_ready_d;

   logic             in_fire;
   logic             main_free;

   // Load lane selection and sign/zero extension from the raw memory word.
   always_comb begin
      case (in_alu[1:0])
         2'd0:    ld_byte = in_rdata[7:0];
         2'd1:    ld_byte = in_rdata[15:8];
         2'd2:    ld_byte = in_rdata[23:16];
         default: ld_byte = in_rdata[31:24];
      endcase
      ld_half = in_alu[1] ? in_rdata[31:16] : in_rdata[15:0];
      case (in_funct)
         F_LB:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F_LBU:   ld_data = XLEN'(ld_byte);
         F_LH:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         F_LHU:   ld_data = XLEN'(ld_half);
         default: ld_data = in_rdata;
      endcase
   end

   // Result select and qualified write enable for the incoming entry.
   always_comb begin
      case (in_sel)
         SEL_ALU:  wb_data_c = in_alu;
         SEL_LOAD: wb_data_c = ld_data;
         SEL_IMM:  wb_data_c = in_immediate;
         SEL_BR:   wb_data_c = XLEN'(in_branch_addr);
         SEL_PC4:  wb_data_c = XLEN'(in_pcplus4);
         default:  wb_data_c = '0;
      endcase
      wb_we_c = in_regwrite && (in_rd != '0);
   end

   assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   // Next-state for main/skid storage: refill main from skid first to keep order.
   always_comb begin
      main_valid_d = main_valid_q;
      main_wdata_d = main_wdata_q;
      main_rd_d    = main_rd_q;
      main_we_d    = main_we_q;
      skid_valid_d = skid_valid_q;
      skid_wdata_d = skid_wdata_q;
      skid_rd_d    = skid_rd_q;
      skid_we_d    = skid_we_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if ((SKID != 0) && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_wdata_d = skid_wdata_q;
            main_rd_d    = skid_rd_q;
            main_we_d    = skid_we_q;
            skid_valid_d = in_fire;
            if (in_fire) begin
               skid_wdata_d = wb_data_c;
               skid_rd_d    = in_rd;
               skid_we_d    = wb_we_c;
            end
         end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
               main_wdata_d = wb_data_c;
               main_rd_d    = in_rd;
               main_we_d    = wb_we_c;
            end
         end
      end else if ((SKID != 0) && in_fire) begin
         skid_valid_d = 1'b1;
         skid_wdata_d = wb_data_c;
         skid_rd_d    = in_rd;
         skid_we_d    = wb_we_c;
      end

      in_ready_d = !skid_valid_d;
   end

   // Storage registers; everything returns to the empty state on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_valid_q <= 1'b0;
         main_wdata_q <= '0;
         main_rd_q    <= '0;
         main_we_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_wdata_q <= '0;
         skid_rd_q    <= '0;
         skid_we_q    <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_wdata_q <= main_wdata_d;
         main_rd_q    <= main_rd_d;
         main_we_q    <= main_we_d;
         skid_valid_q <= skid_valid_d;
         skid_wdata_q <= skid_wdata_d;
         skid_rd_q    <= skid_rd_d;
         skid_we_q    <= skid_we_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign out_valid    = main_valid_q;
   assign out_wdata    = main_wdata_q;
   assign out_rd       = main_rd_q;
   assign out_regwrite = main_we_q && main_valid_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a SKID=1 and a SKID=0 instance share clock, reset,
// flush and payload inputs but have independent handshakes.
module tb_mem_wb_pipe;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned PC_W  = 20;
   localparam int unsigned REG_W = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n;
   logic             flush;
   logic [PC_W-1:0]  in_pcplus4, in_branch_addr;
   logic [XLEN-1:0]  in_immediate, in_rdata, in_alu;
   logic             in_regwrite;
   logic [2:0]       in_sel, in_funct;
   logic [REG_W-1:0] in_rd;

   logic             in_valid1, in_ready1, out_valid1, out_ready1, out_regwrite1;
   logic [XLEN-1:0]  out_wdata1;
   logic [REG_W-1:0] out_rd1;
   logic             in_valid0, in_ready0, out_valid0, out_ready0, out_regwrite0;
   logic [XLEN-1:0]  out_wdata0;
   logic [REG_W-1:0] out_rd0;

   mem_wb_pipe #(.XLEN(XLEN), .PC_W(PC_W), .REG_W(REG_W), .SKID(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_pcplus4(in_pcplus4), .in_branch_addr(in_branch_addr),
      .in_immediate(in_immediate), .in_regwrite(in_regwrite),
      .in_sel(in_sel), .in_funct(in_funct), .in_rdata(in_rdata),
      .in_alu(in_alu), .in_rd(in_rd),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_wdata(out_wdata1),
      .out_regwrite(out_regwrite1), .out_rd(out_rd1));

   mem_wb_pipe #(.XLEN(XLEN), .PC_W(PC_W), .REG_W(REG_W), .SKID(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .in_pcplus4(in_pcplus4), .in_branch_addr(in_branch_addr),
      .in_immediate(in_immediate), .in_regwrite(in_regwrite),
      .in_sel(in_sel), .in_funct(in_funct), .in_rdata(in_rdata),
      .in_alu(in_alu), .in_rd(in_rd),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_wdata(out_wdata0),
      .out_regwrite(out_regwrite0), .out_rd(out_rd0));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference write-back value from the architectural load/select rules.
   function automatic logic [31:0] ref_wdata(input logic [2:0] sel, input logic [2:0] funct,
                                             input logic [31:0] rdata, input logic [31:0] alu,
                                             input logic [31:0] imm, input logic [19:0] br,
                                             input logic [19:0] pc);
      logic [31:0] b, h, ld;
      b = (rdata >> {alu[1:0], 3'b000}) & 32'h0000_00FF;
      h = (rdata >> {alu[1], 4'b0000}) & 32'h0000_FFFF;
      case (funct)
         3'd0:    ld = b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd4:    ld = b;
         3'd1:    ld = h[15] ? (h | 32'hFFFF_0000) : h;
         3'd5:    ld = h;
         default: ld = rdata;
      endcase
      case (sel)
         3'd0:    return alu;
         3'd1:    return ld;
         3'd2:    return imm;
         3'd3:    return {12'h000, br};
         3'd4:    return {12'h000, pc};
         default: return 32'h0;
      endcase
   endfunction

   typedef struct {
      logic [2:0]  sel;
      logic [2:0]  funct;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [31:0] imm;
      logic [19:0] br;
      logic [19:0] pc;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] exp_wdata;
      logic        exp_we;
   } vec_t;

   typedef struct packed {
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        we;
   } ent_t;

   vec_t vecs[$];
   ent_t q1[$];
   ent_t q0[$];

   task automatic add_vec(input logic [2:0] sel, input logic [2:0] funct, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic [31:0] imm, input logic [19:0] br,
                          input logic [19:0] pc, input logic rw, input logic [4:0] rd,
                          input logic [31:0] exp_wdata, input logic exp_we);
      vec_t v;
      v.sel = sel; v.funct = funct; v.rdata = rdata; v.alu = alu; v.imm = imm;
      v.br = br; v.pc = pc; v.rw = rw; v.rd = rd; v.exp_wdata = exp_wdata; v.exp_we = exp_we;
      vecs.push_back(v);
   endtask

   task automatic drive_simple(input logic [31:0] alu, input logic [4:0] rd);
      in_sel = 3'd0; in_funct = 3'd2; in_alu = alu; in_rd = rd; in_regwrite = 1'b1;
      in_rdata = 32'h0; in_immediate = 32'h0; in_pcplus4 = 20'h0; in_branch_addr = 20'h0;
   endtask

   task automatic rand_payload();
      in_sel         = 3'($urandom_range(0, 7));
      in_funct       = 3'($urandom_range(0, 7));
      in_rdata       = $urandom();
      in_alu         = $urandom();
      in_immediate   = $urandom();
      in_pcplus4     = 20'($urandom());
      in_branch_addr = 20'($urandom());
      in_regwrite    = 1'($urandom_range(0, 1));
      in_rd          = 5'($urandom_range(0, 31));
   endtask

   // Fill dut1 with two entries (A in main, B in skid) while WB stalls.
   task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
      out_ready1 = 1'b0;
      drive_simple(a, 5'd1); in_valid1 = 1'b1;
      @(negedge clk);
      drive_simple(b, 5'd2);
      @(negedge clk);
      in_valid1 = 1'b0;
   endtask

   logic [31:0] got[$];
   logic        c_taken;
   ent_t        e, f;

   initial begin
      // Reset with random inputs and live handshakes
      reset_n = 1'b0; flush = 1'b0;
      rand_payload();
      in_valid1 = 1'b1; out_ready1 = 1'b0; in_valid0 = 1'b1; out_ready0 = 1'b0;
      repeat (2) @(negedge clk);
      check_bit ("rst_valid1",  out_valid1,    1'b0);
      check_bit ("rst_we1",     out_regwrite1, 1'b0);
      check_word("rst_wdata1",  out_wdata1,    32'h0);
      check_word("rst_rd1",     32'(out_rd1),  32'h0);
      check_bit ("rst_ready1",  in_ready1,     1'b1);
      check_bit ("rst_valid0",  out_valid0,    1'b0);
      check_bit ("rst_ready0",  in_ready0,     1'b1);
      in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready1 = 1'b1; out_ready0 = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      check_bit("post_rst_ready1", in_ready1, 1'b1);

      // Table-driven select / load-extension vectors
      add_vec(3'd0, 3'd0, 32'h0,         32'h1234, 32'h0, 20'h0, 20'h0, 1'b1, 5'd3,  32'h0000_1234, 1'b1);
      add_vec(3'd1, 3'd0, 32'h80FF_7F01, 32'd3,    32'h0, 20'h0, 20'h0, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b1);
      add_vec(3'd1, 3'd4, 32'h80FF_7F01, 32'd2,    32'h0, 20'h0, 20'h0, 1'b1, 5'd6,  32'h0000_00FF, 1'b1);
      add_vec(3'd1, 3'd1, 32'h80FF_7F01, 32'd2,    32'h0, 20'h0, 20'h0, 1'b1, 5'd7,  32'hFFFF_80FF, 1'b1);
      add_vec(3'd1, 3'd5, 32'h80FF_7F01, 32'd0,    32'h0, 20'h0, 20'h0, 1'b1, 5'd8,  32'h0000_7F01, 1'b1);
      add_vec(3'd1, 3'd2, 32'h80FF_7F01, 32'd1,    32'h0, 20'h0, 20'h0, 1'b1, 5'd9,  32'h80FF_7F01, 1'b1);
      add_vec(3'd1, 3'd0, 32'h80FF_7F01, 32'd1,    32'h0, 20'h0, 20'h0, 1'b1, 5'd10, 32'h0000_007F, 1'b1);
      add_vec(3'd1, 3'd4, 32'h80FF_7F01, 32'd3,    32'h0, 20'h0, 20'h0, 1'b1, 5'd11, 32'h0000_0080, 1'b1);
      add_vec(3'd1, 3'd1, 32'h80FF_7F01, 32'd0,    32'h0, 20'h0, 20'h0, 1'b1, 5'd12, 32'h0000_7F01, 1'b1);
      add_vec(3'd1, 3'd3, 32'h80FF_7F01, 32'd2,    32'h0, 20'h0, 20'h0, 1'b1, 5'd13, 32'h80FF_7F01, 1'b1);
      add_vec(3'd4, 3'd0, 32'h0, 32'h5, 32'h0, 20'h00010, 20'hABCDE, 1'b1, 5'd14, 32'h000A_BCDE, 1'b1);
      add_vec(3'd3, 3'd0, 32'h0, 32'h5, 32'h0, 20'h00010, 20'hABCDE, 1'b1, 5'd15, 32'h0000_0010, 1'b1);
      add_vec(3'd7, 3'd0, 32'hFFFF_FFFF, 32'h55, 32'h77, 20'h1, 20'h2, 1'b1, 5'd16, 32'h0, 1'b1);
      add_vec(3'd5, 3'd0, 32'hFFFF_FFFF, 32'h55, 32'h77, 20'h1, 20'h2, 1'b1, 5'd17, 32'h0, 1'b1);
      add_vec(3'd6, 3'd0, 32'hFFFF_FFFF, 32'h55, 32'h77, 20'h1, 20'h2, 1'b1, 5'd18, 32'h0, 1'b1);
      add_vec(3'd2, 3'd0, 32'h0, 32'h55, 32'hDEAD_B000, 20'h1, 20'h2, 1'b1, 5'd19, 32'hDEAD_B000, 1'b1);
      add_vec(3'd0, 3'd0, 32'h0, 32'h55, 32'h0, 20'h0, 20'h0, 1'b1, 5'd0,  32'h0000_0055, 1'b0);
      add_vec(3'd0, 3'd0, 32'h0, 32'h66, 32'h0, 20'h0, 20'h0, 1'b0, 5'd20, 32'h0000_0066, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         in_sel = vecs[i].sel; in_funct = vecs[i].funct; in_rdata = vecs[i].rdata;
         in_alu = vecs[i].alu; in_immediate = vecs[i].imm; in_branch_addr = vecs[i].br;
         in_pcplus4 = vecs[i].pc; in_regwrite = vecs[i].rw; in_rd = vecs[i].rd;
         in_valid1 = 1'b1; out_ready1 = 1'b1;
         @(negedge clk);
         in_valid1 = 1'b0;
         check_bit ($sformatf("vec%0d_valid", i), out_valid1,    1'b1);
         check_word($sformatf("vec%0d_wdata", i), out_wdata1,    vecs[i].exp_wdata);
         check_bit ($sformatf("vec%0d_we", i),    out_regwrite1, vecs[i].exp_we);
         check_word($sformatf("vec%0d_rd", i),    32'(out_rd1),  32'(vecs[i].rd));
      end
      @(negedge clk);
      check_bit("idle_valid", out_valid1, 1'b0);

      // Backpressure: A, B, C offered back-to-back with WB stalled
      out_ready1 = 1'b0;
      drive_simple(32'hA, 5'd1); in_valid1 = 1'b1;
      @(negedge clk);
      check_bit ("bp_a_valid", out_valid1, 1'b1);
      check_word("bp_a_wdata", out_wdata1, 32'hA);
      check_bit ("bp_a_ready", in_ready1,  1'b1);
      drive_simple(32'hB, 5'd2);
      @(negedge clk);
      check_bit ("bp_b_ready", in_ready1,  1'b0);
      check_word("bp_b_head",  out_wdata1, 32'hA);
      drive_simple(32'hC, 5'd3);
      @(negedge clk);
      check_bit ("bp_c_held_ready", in_ready1,  1'b0);
      check_word("bp_c_held_head",  out_wdata1, 32'hA);
      out_ready1 = 1'b1;
      got.delete(); c_taken = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid1 && out_ready1) got.push_back(out_wdata1);
         if (in_valid1 && in_ready1) c_taken = 1'b1;
         @(posedge clk); #1;
         if (c_taken) in_valid1 = 1'b0;
         @(negedge clk);
      end
      check_word("bp_count", 32'(got.size()), 32'd3);
      check_word("bp_out0", (got.size() > 0) ? got[0] : 32'hDEAD, 32'hA);
      check_word("bp_out1", (got.size() > 1) ? got[1] : 32'hDEAD, 32'hB);
      check_word("bp_out2", (got.size() > 2) ? got[2] : 32'hDEAD, 32'hC);

      // Flush with two entries held and a new entry offered
      fill_two(32'h111, 32'h222);
      drive_simple(32'h333, 5'd4); in_valid1 = 1'b1; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid1 = 1'b0;
      check_bit ("fl2_valid", out_valid1,    1'b0);
      check_bit ("fl2_we",    out_regwrite1, 1'b0);
      check_bit ("fl2_ready", in_ready1,     1'b1);
      check_word("fl2_stale", out_wdata1,    32'h111);
      out_ready1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_bit($sformatf("fl2_gone%0d", i), out_valid1, 1'b0);
      end

      // Flush with one entry held and a concurrent accepted input
      out_ready1 = 1'b0;
      drive_simple(32'h444, 5'd5); in_valid1 = 1'b1;
      @(negedge clk);
      drive_simple(32'h555, 5'd6);
      check_bit("fl1_ready_pre", in_ready1, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid1 = 1'b0;
      check_bit ("fl1_valid", out_valid1, 1'b0);
      check_bit ("fl1_ready", in_ready1,  1'b1);
      check_word("fl1_stale", out_wdata1, 32'h444);
      out_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit($sformatf("fl1_gone%0d", i), out_valid1, 1'b0);
      end

      // Asynchronous reset while two entries are held
      fill_two(32'h666, 32'h777);
      #2 reset_n = 1'b0;
      #1;
      check_bit ("arst_valid", out_valid1, 1'b0);
      check_bit ("arst_ready", in_ready1,  1'b1);
      check_word("arst_wdata", out_wdata1, 32'h0);
      @(negedge clk);
      reset_n = 1'b1; out_ready1 = 1'b1;
      @(negedge clk);
      check_bit("arst_after", out_valid1, 1'b0);

      // Random traffic on both builds against the queue model
      q1.delete(); q0.delete();
      for (int cyc = 0; cyc < 1200; cyc++) begin
         check_bit("rnd1_valid", out_valid1, q1.size() != 0);
         check_bit("rnd1_ready", in_ready1,  q1.size() < 2);
         check_bit("rnd0_valid", out_valid0, q0.size() != 0);
         if (!out_valid1) check_bit("rnd1_we_idle", out_regwrite1, 1'b0);
         if (!out_valid0) check_bit("rnd0_we_idle", out_regwrite0, 1'b0);

         rand_payload();
         flush      = ($urandom_range(0, 39) == 0);
         in_valid1  = ($urandom_range(0, 3) != 0);
         out_ready1 = ($urandom_range(0, 2) != 0);
         in_valid0  = ($urandom_range(0, 3) != 0);
         out_ready0 = ($urandom_range(0, 2) != 0);
         #1;
         check_bit("rnd0_ready_eq", in_ready0, !out_valid0 || out_ready0);

         e.wdata = ref_wdata(in_sel, in_funct, in_rdata, in_alu, in_immediate,
                             in_branch_addr, in_pcplus4);
         e.rd    = in_rd;
         e.we    = in_regwrite && (in_rd != 5'd0);

         if (out_valid1 && out_ready1 && q1.size() > 0) begin
            f = q1.pop_front();
            check_word("rnd1_wdata", out_wdata1, f.wdata);
            check_word("rnd1_rd", 32'(out_rd1), 32'(f.rd));
            check_bit ("rnd1_we", out_regwrite1, f.we);
         end
         if (flush) q1.delete();
         else if (in_valid1 && in_ready1) q1.push_back(e);

         if (out_valid0 && out_ready0 && q0.size() > 0) begin
            f = q0.pop_front();
            check_word("rnd0_wdata", out_wdata0, f.wdata);
            check_word("rnd0_rd", 32'(out_rd0), 32'(f.rd));
            check_bit ("rnd0_we", out_regwrite0, f.we);
         end
         if (flush) q0.delete();
         else if (in_valid0 && in_ready0) q0.push_back(e);

         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
